// File: rtl/region_dispatcher_if.sv
// AXI4-Stream style handshake bundle carrying HTTP metadata beats.
interface region_dispatcher_if #(
   parameter int WIDTH = 8
);
   logic             tvalid;
   logic             tready;
   logic [WIDTH-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/region_dispatcher.sv
// Region dispatcher: registers a metadata beat with its region decision,
// forwards it to the selected region's stream port, tracks outstanding
// load per region, stores per-region operator IDs and publishes both as
// a packed statistics vector for the load balancer.
module region_dispatcher #(
   parameter int HTTP_META_WIDTH   = 8,
   parameter int OPERATOR_ID_WIDTH = 2,
   parameter int N_REGIONS         = 4,
   parameter int QDEPTH            = 4
) (
   input  logic                                    aclk,
   input  logic                                    aresetn,
   region_dispatcher_if.slave                      meta_in,
   input  logic [$clog2(N_REGIONS)-1:0]            lb_ctrl,
   output logic [N_REGIONS-1:0]                    region_tvalid,
   input  logic [N_REGIONS-1:0]                    region_tready,
   output logic [N_REGIONS*HTTP_META_WIDTH-1:0]    region_tdata,
   input  logic [N_REGIONS-1:0]                    region_done,
   input  logic                                    cfg_valid,
   output logic                                    cfg_ready,
   input  logic [$clog2(N_REGIONS)-1:0]            cfg_region,
   input  logic [OPERATOR_ID_WIDTH-1:0]            cfg_oid,
   output logic [N_REGIONS*(OPERATOR_ID_WIDTH+$clog2(QDEPTH))-1:0] region_stats,
   output logic                                    err_underflow
);
   localparam int RB        = $clog2(N_REGIONS);
   localparam int PNTR_BITS = $clog2(QDEPTH);
   localparam int SW        = OPERATOR_ID_WIDTH + PNTR_BITS;
   localparam logic [PNTR_BITS-1:0] LOAD_MAX = PNTR_BITS'(QDEPTH - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t                       state_r;
   logic [RB-1:0]                hold_region_r;
   logic [HTTP_META_WIDTH-1:0]   hold_data_r;
   logic [PNTR_BITS-1:0]         load_r [N_REGIONS];
   logic [OPERATOR_ID_WIDTH-1:0] oid_r  [N_REGIONS];
   logic                         err_underflow_r;

   logic                         hold_valid_s;
   logic [N_REGIONS-1:0]         fire_s;
   logic                         out_fire_s;
   logic                         in_fire_s;
   logic                         cfg_fire_s;

   assign hold_valid_s = (state_r == HOLD);

   // Present the held beat only to its target region, and only while that region has room.
   always_comb begin
      region_tvalid = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (hold_valid_s && (hold_region_r == RB'(i)) && (load_r[i] != LOAD_MAX)) begin
            region_tvalid[i] = 1'b1;
         end else begin
            region_tvalid[i] = 1'b0;
         end
      end
   end

   // At most one valid is high, so the per-region fire vector identifies the dispatch target.
   assign fire_s         = region_tvalid & region_tready;
   assign out_fire_s     = |fire_s;
   assign meta_in.tready = !hold_valid_s || out_fire_s;
   assign in_fire_s      = meta_in.tvalid && meta_in.tready;
   assign region_tdata   = {N_REGIONS{hold_data_r}};

   // A region may only be reconfigured when it is fully drained and nothing is waiting for it.
   assign cfg_ready  = (load_r[cfg_region] == '0) &&
                       !(hold_valid_s && (hold_region_r == cfg_region));
   assign cfg_fire_s = cfg_valid && cfg_ready;

   assign err_underflow = err_underflow_r;

   genvar g;
   generate
      for (g = 0; g < N_REGIONS; g++) begin : g_stats
         assign region_stats[g*SW +: SW] = {oid_r[g], load_r[g]};
      end
   endgenerate

   // Holding-register FSM plus per-region load/oid bookkeeping and the sticky underflow flag.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r         <= IDLE;
         hold_region_r   <= '0;
         hold_data_r     <= '0;
         err_underflow_r <= 1'b0;
         for (int i = 0; i < N_REGIONS; i++) begin
            load_r[i] <= '0;
            oid_r[i]  <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (in_fire_s) begin
                  state_r       <= HOLD;
                  hold_region_r <= lb_ctrl;
                  hold_data_r   <= meta_in.tdata;
               end else begin
                  state_r <= IDLE;
               end
            end
            HOLD: begin
               if (in_fire_s) begin
                  state_r       <= HOLD;
                  hold_region_r <= lb_ctrl;
                  hold_data_r   <= meta_in.tdata;
               end else if (out_fire_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase

         // Dispatch and completion on the same edge cancel; done at zero is flagged, never wrapped.
         for (int i = 0; i < N_REGIONS; i++) begin
            if (fire_s[i] && !region_done[i]) begin
               load_r[i] <= load_r[i] + PNTR_BITS'(1);
            end else if (!fire_s[i] && region_done[i]) begin
               if (load_r[i] == '0) begin
                  err_underflow_r <= 1'b1;
               end else begin
                  load_r[i] <= load_r[i] - PNTR_BITS'(1);
               end
            end else begin
               load_r[i] <= load_r[i];
            end
         end

         if (cfg_fire_s) begin
            oid_r[cfg_region] <= cfg_oid;
         end else begin
            oid_r[cfg_region] <= oid_r[cfg_region];
         end
      end
   end
endmodule
